// File: rtl/memory_access_stage.sv
// MEM pipeline stage: synchronous single-port data RAM with a registered read result
// and export registers that mirror the last accepted request for a monitor/debug bus.
module memory_access_stage #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned MEM_DEPTH  = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] datamem_data,
    input  logic [ADDR_WIDTH-1:0] datamem_address,
    input  logic                  ctr_datamem_MR,
    input  logic                  ctr_datamem_MW,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] datamem_export_out,
    output logic [DATA_WIDTH-1:0] datamem_export_data,
    output logic [ADDR_WIDTH-1:0] datamem_export_address,
    output logic                  datamem_export_MR,
    output logic                  datamem_export_MW
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  in_range_c;
    logic                  accept_c;
    logic                  wr_en_c;
    logic [IDX_W-1:0]      idx_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    logic [DATA_WIDTH-1:0] data_q,     data_d;
    logic [DATA_WIDTH-1:0] exp_data_q, exp_data_d;
    logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
    logic                  exp_mr_q,   exp_mr_d;
    logic                  exp_mw_q,   exp_mw_d;

    // A fully populated address space needs no range check.
    generate
        if (MEM_DEPTH >= 2**ADDR_WIDTH) begin : g_full
            assign in_range_c = 1'b1;
        end else begin : g_partial
            assign in_range_c = (datamem_address < ADDR_WIDTH'(MEM_DEPTH));
        end
    endgenerate

    assign idx_c     = datamem_address[IDX_W-1:0];
    assign accept_c  = enable & (ctr_datamem_MR | ctr_datamem_MW);
    assign wr_en_c   = enable & ctr_datamem_MW & in_range_c;
    assign rd_word_c = in_range_c ? mem[idx_c] : '0;

    // Next-state for the read result and the export mirror.
    always_comb begin
        data_d     = data_q;
        exp_data_d = exp_data_q;
        exp_addr_d = exp_addr_q;
        exp_mr_d   = exp_mr_q;
        exp_mw_d   = exp_mw_q;
        if (accept_c) begin
            exp_data_d = datamem_data;
            exp_addr_d = datamem_address;
            exp_mr_d   = ctr_datamem_MR;
            exp_mw_d   = ctr_datamem_MW;
            if (ctr_datamem_MR && ctr_datamem_MW) begin
                data_d = in_range_c ? datamem_data : '0;
            end else if (ctr_datamem_MR) begin
                data_d = rd_word_c;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q     <= '0;
            exp_data_q <= '0;
            exp_addr_q <= '0;
            exp_mr_q   <= 1'b0;
            exp_mw_q   <= 1'b0;
        end else begin
            data_q     <= data_d;
            exp_data_q <= exp_data_d;
            exp_addr_q <= exp_addr_d;
            exp_mr_q   <= exp_mr_d;
            exp_mw_q   <= exp_mw_d;
        end
    end

    // RAM array is never cleared; a write coinciding with reset low is dropped.
    always_ff @(posedge clk) begin
        if (reset && wr_en_c) begin
            mem[idx_c] <= datamem_data;
        end
    end

    assign data_out               = data_q;
    assign datamem_export_out     = data_q;
    assign datamem_export_data    = exp_data_q;
    assign datamem_export_address = exp_addr_q;
    assign datamem_export_MR      = exp_mr_q;
    assign datamem_export_MW      = exp_mw_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed scenarios plus a randomized run against a
// word-level behavioural model of the stage.
module tb_memory_access_stage;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 11;
    localparam int unsigned DEPTH = 1536;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] datamem_data;
    logic [AW-1:0] datamem_address;
    logic          mr, mw;
    logic [DW-1:0] data_out, export_out, export_data;
    logic [AW-1:0] export_address;
    logic          export_mr, export_mw;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [DW-1:0] m_mem [2**AW];
    logic [DW-1:0] m_out, m_ed;
    logic [AW-1:0] m_ea;
    logic          m_mr, m_mw;

    memory_access_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .enable                 (enable),
        .datamem_data           (datamem_data),
        .datamem_address        (datamem_address),
        .ctr_datamem_MR         (mr),
        .ctr_datamem_MW         (mw),
        .data_out               (data_out),
        .datamem_export_out     (export_out),
        .datamem_export_data    (export_data),
        .datamem_export_address (export_address),
        .datamem_export_MR      (export_mr),
        .datamem_export_MW      (export_mw)
    );

    always #5 clk = ~clk;

    // Apply the stage's rules to the inputs that will be seen at the coming edge.
    task automatic model_edge();
        if (reset === 1'b1 && enable === 1'b1 && (mr === 1'b1 || mw === 1'b1)) begin
            m_ed = datamem_data;
            m_ea = datamem_address;
            m_mr = mr;
            m_mw = mw;
            if (mr && mw) begin
                m_out = (int'(datamem_address) < DEPTH) ? datamem_data : '0;
            end else if (mr) begin
                m_out = (int'(datamem_address) < DEPTH) ? m_mem[datamem_address] : '0;
            end
            if (mw && int'(datamem_address) < DEPTH) m_mem[datamem_address] = datamem_data;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        enable = en; mr = r; mw = w; datamem_address = a; datamem_data = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        m_out = '0; m_ed = '0; m_ea = '0; m_mr = 1'b0; m_mw = 1'b0;
        repeat (4) tick();
        total++;
        if ({data_out, export_out, export_data, export_address, export_mr, export_mw} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got out=%h exp_out=%h ed=%h ea=%h mr=%b mw=%b want all 0",
                     data_out, export_out, export_data, export_address, export_mr, export_mw);
        end
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 11'h2A5, 16'hBEEF);
        repeat (3) tick();
        total++;
        if ({data_out, export_out, export_data, export_address, export_mr, export_mw} !== '0) begin
            bad++;
            $display("FAIL release_disabled: got out=%h ed=%h ea=%h mr=%b mw=%b want all 0",
                     data_out, export_data, export_address, export_mr, export_mw);
        end
    endtask

    task automatic test_write();
        logic [DW-1:0] wd [4] = '{16'd4, 16'd3, 16'd2, 16'd1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, AW'(i), wd[i]);
            tick();
            total++;
            if (data_out !== 16'd0 || export_address !== AW'(i) || export_data !== wd[i]
                || export_mr !== 1'b0 || export_mw !== 1'b1) begin
                bad++;
                $display("FAIL write_%0d: got out=%h ea=%h ed=%h mr=%b mw=%b want out=0 ea=%h ed=%h mr=0 mw=1",
                         i, data_out, export_address, export_data, export_mr, export_mw, i, wd[i]);
            end
        end
    endtask

    task automatic test_read();
        logic [DW-1:0] wd [4] = '{16'd4, 16'd3, 16'd2, 16'd1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, AW'(i), 16'h5A5A);
            tick();
            total++;
            if (data_out !== wd[i] || export_out !== wd[i] || export_address !== AW'(i)) begin
                bad++;
                $display("FAIL read_%0d: got out=%h copy=%h ea=%h want %h at ea=%h",
                         i, data_out, export_out, export_address, wd[i], i);
            end
        end
    endtask

    task automatic test_write_through();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, AW'(i), 16'hF00F);
            tick();
            total++;
            if (data_out !== 16'hF00F || export_mr !== 1'b1 || export_mw !== 1'b1) begin
                bad++;
                $display("FAIL write_through_%0d: got out=%h mr=%b mw=%b want F00F 1 1",
                         i, data_out, export_mr, export_mw);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, 1'b1, 1'b0, AW'(i), 16'h0);
            tick();
            total++;
            if (data_out !== 16'hF00F) begin
                bad++;
                $display("FAIL wt_readback_%0d: got %h want F00F", i, data_out);
            end
        end
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b0, 1'b1, 11'd2, 16'h1234);
        repeat (2) tick();
        total++;
        if (data_out !== 16'hF00F || export_address !== 11'd0 || export_data !== 16'h0
            || export_mr !== 1'b1 || export_mw !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold: got out=%h ea=%h ed=%h mr=%b mw=%b want F00F 0 0 1 0",
                     data_out, export_address, export_data, export_mr, export_mw);
        end
        drive(1'b0, 1'b1, 1'b0, 11'd3, 16'hAAAA);
        tick();
        drive(1'b1, 1'b1, 1'b0, 11'd2, 16'h0);
        tick();
        total++;
        if (data_out !== 16'hF00F || export_address !== 11'd2) begin
            bad++;
            $display("FAIL stall_no_write: got out=%h ea=%h want F00F ea=2", data_out, export_address);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b1, 11'd4, 16'hF00F);
        tick();
        drive(1'b1, 1'b0, 1'b1, 11'd0, 16'hDEAD);
        #1 reset = 1'b0;
        m_out = '0; m_ed = '0; m_ea = '0; m_mr = 1'b0; m_mw = 1'b0;
        #1;
        total++;
        if ({data_out, export_out, export_data, export_address, export_mr, export_mw} !== '0) begin
            bad++;
            $display("FAIL reset_async: got out=%h ed=%h ea=%h mr=%b mw=%b want all 0",
                     data_out, export_data, export_address, export_mr, export_mw);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, AW'(i), 16'h0);
            tick();
            total++;
            if (data_out !== 16'hF00F) begin
                bad++;
                $display("FAIL survive_reset_%0d: got %h want F00F", i, data_out);
            end
        end
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 1'b0, 1'b1, AW'(DEPTH - 1), 16'h7E57);
        tick();
        drive(1'b1, 1'b0, 1'b1, AW'(DEPTH), 16'h9999);
        tick();
        drive(1'b1, 1'b1, 1'b0, AW'(DEPTH - 1), 16'h0);
        tick();
        total++;
        if (data_out !== 16'h7E57) begin
            bad++;
            $display("FAIL last_word: got %h want 7E57", data_out);
        end
        drive(1'b1, 1'b1, 1'b0, AW'(DEPTH), 16'h3C3C);
        tick();
        total++;
        if (data_out !== 16'h0 || export_address !== AW'(DEPTH) || export_data !== 16'h3C3C) begin
            bad++;
            $display("FAIL oob_read: got out=%h ea=%h ed=%h want 0 %h 3C3C",
                     data_out, export_address, export_data, AW'(DEPTH));
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic          r, w;
        int            pick;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b1, AW'(i), DW'($urandom));
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b1, AW'(DEPTH - 6 + i), DW'($urandom));
            tick();
        end
        for (int n = 0; n < 300; n++) begin
            pick = int'($urandom_range(0, 31));
            a = (pick < 16) ? AW'(pick) : AW'(DEPTH - 6 + pick - 16);
            r = 1'($urandom);
            w = 1'($urandom);
            if (r && w && int'(a) >= DEPTH) a = AW'(pick - 16);
            drive(1'($urandom_range(0, 3) != 0), r, w, a, DW'($urandom));
            tick();
            total++;
            if ({data_out, export_out, export_data, export_address, export_mr, export_mw}
                !== {m_out, m_out, m_ed, m_ea, m_mr, m_mw}) begin
                bad++;
                $display("FAIL random_%0d: got out=%h copy=%h ed=%h ea=%h mr=%b mw=%b want out=%h ed=%h ea=%h mr=%b mw=%b",
                         n, data_out, export_out, export_data, export_address, export_mr, export_mw,
                         m_out, m_ed, m_ea, m_mr, m_mw);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_write_through();
        test_stall();
        test_reset_mid();
        test_out_of_range();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
